uart_move_sequencer: RTL and testbench
======================================

// Module: uart_move_sequencer
// PURPOSE
//  Takes move command bytes from the UART receiver, queues them in a small FIFO and runs each
//  one as a timed servo cycle: grip, rotate, release, return.
//  Sits between uart_rx (byte/valid strobe) and the servo PWM generators in Top_level.
//  Bytes arrive over the serial link while a move is running, so the FIFO absorbs them.
// PARAMETERS
//  FIFO_DEPTH  4            command slots; power of 2, >=2
//  T_GRIP_CYC  50_000_000   clock cycles held in GRIP and in RELEASE
//  T_ROT_CYC   100_000_000  clock cycles held in ROTATE and in RETURN
// PORTS
//  I_sys_clk       in   1   system clock; one clock domain
//  I_rst           in   1   reset, synchronous, active-high
//  I_rx_byte       in   8   received byte; valid only while I_rx_valid=1
//  I_rx_valid      in   1   one-cycle strobe from uart_rx
//  o_grip          out  4   gripping servo enables {bottom,top,right,left}
//  o_rot_en        out  4   directional servo enables; 1 = arm at rotated position
//  o_rot_ccw       out  1   rotation sense for the active move; 0 = CW, 1 = CCW
//  o_busy          out  1   1 when state != IDLE or the FIFO is non-empty
//  o_move_done     out  1   one-cycle pulse when a move finishes
//  o_cmd_error     out  1   one-cycle pulse when an illegal byte is dropped
//  o_overflow      out  1   sticky; set when a legal byte is dropped because the FIFO is full
//  o_fifo_count    out  $clog2(FIFO_DEPTH)+1   number of queued commands
//  o_state         out  3   state code for the debug LEDs
// BEHAVIOUR
//  Reset (I_rst=1 at posedge):
//   - state=IDLE; FIFO flushed; timer=0.
//   - Every output is 0, including o_overflow.
//   - Reset takes effect from any state, mid-move included; servo outputs drop to 0 on the next edge.
//  Byte format:
//   - [3:0] = row mask {bottom,top,right,left}; [4] = ccw; [7:5] must be 000.
//   - Legal masks: 0001, 0010, 0100, 1000, 0011 (left+right), 1100 (top+bottom).
//   - Any other byte: not queued; o_cmd_error pulses on the cycle after the strobe.
//  FIFO push and pop:
//   - A legal byte is pushed on the I_rx_valid edge; o_fifo_count updates after that edge.
//   - Full with no pop on that edge: byte dropped, o_overflow set and held until reset.
//   - Full with a pop on the same edge: the push is accepted and the count is unchanged.
//   - Pointers wrap modulo FIFO_DEPTH. A pop when empty never occurs.
//  State machine (timer counts cycles spent in the current state):
//   - IDLE: if FIFO non-empty, pop the head and latch mask/ccw -> GRIP.
//   - GRIP, T_GRIP_CYC cycles: o_grip=mask, o_rot_en=0.
//   - ROTATE, T_ROT_CYC cycles: o_grip=mask, o_rot_en=mask.
//   - RELEASE, T_GRIP_CYC cycles: o_grip=0, o_rot_en=mask.
//   - RETURN, T_ROT_CYC cycles: both 0 -> IDLE; o_move_done=1 on the first IDLE cycle.
//   - o_rot_ccw holds the latched ccw from GRIP to the end of RETURN; it is 0 in IDLE.
//   - Every state is left when timer==T-1, so each state lasts exactly T cycles.
//   - Timer width is $clog2(T_ROT_CYC); timer clears on every state change.
//  Timing:
//   - All outputs are registered. Strobe at edge k -> o_grip asserted after edge k+2.
//   - Back-to-back moves: exactly one IDLE cycle between RETURN and the next GRIP.
//   - A move is 2*T_GRIP_CYC + 2*T_ROT_CYC cycles long.
//  o_state codes: IDLE=0, GRIP=1, ROTATE=2, RELEASE=3, RETURN=4.
// TESTING  (bench parameters: T_GRIP_CYC=4, T_ROT_CYC=8, FIFO_DEPTH=4)
//  1. Single move, byte 0x01:
//     - o_grip=0001 for 12 cycles; o_rot_en=0001 for 12 cycles, starting 4 cycles after grip.
//     - o_rot_ccw=0; o_move_done pulses 24 cycles after GRIP entry; then o_busy=0.
//  2. Bytes 0x1C then 0x03, 2 cycles apart:
//     - Moves run in order: first o_grip=1100 with o_rot_ccw=1, then o_grip=0011 with o_rot_ccw=0.
//     - One IDLE cycle between the two moves; o_move_done pulses twice.
//  3. Bytes 0x05, 0x20, 0x00:
//     - o_cmd_error pulses 3 times; o_fifo_count stays 0; no servo output toggles.
//  4. Six legal bytes during one move:
//     - Fifth or sixth byte drops and o_overflow=1.
//     - Simultaneous push and pop on a full FIFO is accepted.
//     - Pointers wrap; all queued moves complete in arrival order.
//  5. I_rst=1 for one cycle in the middle of ROTATE:
//     - Next cycle: o_grip=0, o_rot_en=0, o_fifo_count=0, o_overflow=0, o_state=0.
//     - A new 0x02 byte afterwards runs normally.

Source files
------------

// File: rtl/uart_move_sequencer.sv
// -----------------------------------------------------------------------------
// uart_move_sequencer
//   Accepts move command bytes from uart_rx, queues them in a small FIFO and
//   plays each one as a timed servo cycle: GRIP -> ROTATE -> RELEASE -> RETURN.
//
//   Command byte: [3:0] row mask {bottom,top,right,left}, [4] ccw, [7:5] = 000.
//   Legal masks are single arms or the opposing pairs 0011 / 1100.
//
// Ports
//   I_sys_clk     system clock
//   I_rst         synchronous active-high reset
//   I_rx_byte     received byte, qualified by I_rx_valid
//   I_rx_valid    one-cycle strobe from uart_rx
//   o_grip        gripping servo enables
//   o_rot_en      directional servo enables (1 = rotated position)
//   o_rot_ccw     rotation sense of the active move, 0 in IDLE
//   o_busy        state != IDLE or FIFO non-empty
//   o_move_done   one-cycle pulse on the first IDLE cycle after RETURN
//   o_cmd_error   one-cycle pulse when an illegal byte is dropped
//   o_overflow    sticky, a legal byte was dropped on a full FIFO
//   o_fifo_count  number of queued commands
//   o_state       state code for debug LEDs
//
//   All outputs are registered from the current state, so they trail the
//   internal state register by one cycle.
// -----------------------------------------------------------------------------
module uart_move_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int T_GRIP_CYC = 50_000_000,
    parameter int T_ROT_CYC  = 100_000_000
) (
    input  logic                          I_sys_clk,
    input  logic                          I_rst,
    input  logic [7:0]                    I_rx_byte,
    input  logic                          I_rx_valid,
    output logic [3:0]                    o_grip,
    output logic [3:0]                    o_rot_en,
    output logic                          o_rot_ccw,
    output logic                          o_busy,
    output logic                          o_move_done,
    output logic                          o_cmd_error,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic [2:0]                    o_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(T_ROT_CYC);

    localparam logic [TMR_W-1:0] GRIP_LAST = TMR_W'(T_GRIP_CYC - 1);
    localparam logic [TMR_W-1:0] ROT_LAST  = TMR_W'(T_ROT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRIP    = 3'd1,
        ST_ROTATE  = 3'd2,
        ST_RELEASE = 3'd3,
        ST_RETURN  = 3'd4
    } state_t;

    state_t             state, next_state;
    logic [TMR_W-1:0]   timer;
    logic [3:0]         mask_q;
    logic               ccw_q;

    logic [4:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               rx_legal, push_req, push_ok, pop, fifo_full;
    logic [3:0]         grip_d, rot_d;

    // Command decode.
    // NOTE: every signal assigned in always_comb gets a default first; a path
    // that leaves one unassigned infers a latch.
    always_comb begin
        rx_legal = 1'b0;
        if (I_rx_byte[7:5] == 3'b000) begin
            case (I_rx_byte[3:0])
                4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100: rx_legal = 1'b1;
                default: rx_legal = 1'b0;
            endcase
        end
    end

    assign push_req  = I_rx_valid && rx_legal;
    assign fifo_full = (count == CNT_FULL);
    assign pop       = (state == ST_IDLE) && (count != '0);
    // A full FIFO still accepts a byte on the edge that pops the head.
    assign push_ok   = push_req && (!fifo_full || pop);

    // NOTE: the command storage has no reset; entries are only ever read
    // behind the count, which is reset, so stale contents are never used.
    always_ff @(posedge I_sys_clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= I_rx_byte[4:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointer width is log2(depth), so increments wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Next-state logic; each timed state is left when timer == T-1.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (pop)                next_state = ST_GRIP;
            ST_GRIP:    if (timer == GRIP_LAST) next_state = ST_ROTATE;
            ST_ROTATE:  if (timer == ROT_LAST)  next_state = ST_RELEASE;
            ST_RELEASE: if (timer == GRIP_LAST) next_state = ST_RETURN;
            ST_RETURN:  if (timer == ROT_LAST)  next_state = ST_IDLE;
            default:                            next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state  <= ST_IDLE;
            timer  <= '0;
            mask_q <= '0;
            ccw_q  <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state != state || state == ST_IDLE) timer <= '0;
            else                                         timer <= timer + TMR_W'(1);
            if (pop) {ccw_q, mask_q} <= fifo_mem[rd_ptr];
        end
    end

    // Servo pattern for the current state.
    always_comb begin
        grip_d = 4'h0;
        rot_d  = 4'h0;
        case (state)
            ST_GRIP:    grip_d = mask_q;
            ST_ROTATE: begin
                grip_d = mask_q;
                rot_d  = mask_q;
            end
            ST_RELEASE: rot_d  = mask_q;
            default: begin
                grip_d = 4'h0;
                rot_d  = 4'h0;
            end
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            o_grip       <= '0;
            o_rot_en     <= '0;
            o_rot_ccw    <= 1'b0;
            o_busy       <= 1'b0;
            o_move_done  <= 1'b0;
            o_cmd_error  <= 1'b0;
            o_overflow   <= 1'b0;
            o_fifo_count <= '0;
            o_state      <= '0;
        end else begin
            o_grip       <= grip_d;
            o_rot_en     <= rot_d;
            o_rot_ccw    <= (state != ST_IDLE) && ccw_q;
            o_busy       <= (state != ST_IDLE) || (count != '0);
            // o_state still shows RETURN on the first IDLE cycle of the state
            // register, which lines the pulse up with o_state going to 0.
            o_move_done  <= (state == ST_IDLE) && (o_state == ST_RETURN);
            o_cmd_error  <= I_rx_valid && !rx_legal;
            o_overflow   <= o_overflow || (push_req && fifo_full && !pop);
            o_fifo_count <= (push_ok && !pop) ? count + CNT_W'(1) :
                            (!push_ok && pop) ? count - CNT_W'(1) : count;
            o_state      <= state;
        end
    end

endmodule

// File: tb/tb_uart_move_sequencer.sv
// -----------------------------------------------------------------------------
// tb_uart_move_sequencer
//   Scoreboard bench: stimulus pushes expected moves and error pulses into
//   queues, a monitor process compares each move's 25-cycle output profile
//   and each o_cmd_error pulse against them.
// -----------------------------------------------------------------------------
module tb_uart_move_sequencer;

    localparam int T_GRIP   = 4;
    localparam int T_ROT    = 8;
    localparam int DEPTH    = 4;
    localparam int MOVE_LEN = 2 * T_GRIP + 2 * T_ROT;

    logic       I_sys_clk_tb  = 1'b0;
    logic       I_rst_tb      = 1'b1;
    logic [7:0] I_rx_byte_tb  = 8'h00;
    logic       I_rx_valid_tb = 1'b0;
    logic [3:0] o_grip, o_rot_en;
    logic       o_rot_ccw, o_busy, o_move_done, o_cmd_error, o_overflow;
    logic [2:0] o_fifo_count;
    logic [2:0] o_state;

    uart_move_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .T_GRIP_CYC (T_GRIP),
        .T_ROT_CYC  (T_ROT)
    ) dut (
        .I_sys_clk    (I_sys_clk_tb),
        .I_rst        (I_rst_tb),
        .I_rx_byte    (I_rx_byte_tb),
        .I_rx_valid   (I_rx_valid_tb),
        .o_grip       (o_grip),
        .o_rot_en     (o_rot_en),
        .o_rot_ccw    (o_rot_ccw),
        .o_busy       (o_busy),
        .o_move_done  (o_move_done),
        .o_cmd_error  (o_cmd_error),
        .o_overflow   (o_overflow),
        .o_fifo_count (o_fifo_count),
        .o_state      (o_state)
    );

    always #5 I_sys_clk_tb = ~I_sys_clk_tb;

    int cyc = 0;
    always @(posedge I_sys_clk_tb) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] mask;
        logic       ccw;
        int         gap;   // expected cycles since previous move start, 0 = don't care
    } move_t;

    move_t move_q[$];
    int    err_q[$];
    int    n_checks   = 0;
    int    n_errors   = 0;
    bit    mon_flush  = 1'b1;
    bit    mon_active = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {grip, rot_en, rot_ccw, state, move_done, busy} rel cycles after o_grip rises.
    function automatic logic [13:0] profile(input int rel, input logic [3:0] m, input logic c);
        logic [3:0] g, r;
        logic [2:0] s;
        g = (rel < T_GRIP + T_ROT) ? m : 4'h0;
        r = (rel >= T_GRIP && rel < 2 * T_GRIP + T_ROT) ? m : 4'h0;
        if (rel < T_GRIP)                   s = 3'd1;
        else if (rel < T_GRIP + T_ROT)      s = 3'd2;
        else if (rel < 2 * T_GRIP + T_ROT)  s = 3'd3;
        else                                s = 3'd4;
        return {g, r, c, s, 1'b0, 1'b1};
    endfunction

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin : monitor
        int    rel;
        int    last_start;
        move_t cur;
        rel        = 0;
        last_start = 0;
        cur        = '{mask: 4'h0, ccw: 1'b0, gap: 0};
        forever begin
            @(negedge I_sys_clk_tb);
            if (mon_flush) begin
                mon_active = 1'b0;
                continue;
            end
            if (o_cmd_error) begin
                check("cmd_error_expected", err_q.size() != 0, 1);
                if (err_q.size() != 0) check("cmd_error_cycle", cyc, err_q.pop_front());
            end
            if (!mon_active) begin
                if (o_move_done) check("spurious_move_done", o_move_done, 0);
                if (o_grip != 4'h0) begin
                    check("move_expected", move_q.size() != 0, 1);
                    if (move_q.size() != 0) begin
                        cur = move_q.pop_front();
                        if (cur.gap != 0) check("move_gap", cyc - last_start, cur.gap);
                        last_start = cyc;
                        rel        = 0;
                        mon_active = 1'b1;
                    end
                end
            end
            if (mon_active) begin
                if (rel < MOVE_LEN) begin
                    check($sformatf("move_profile_rel%0d", rel),
                          {o_grip, o_rot_en, o_rot_ccw, o_state, o_move_done, o_busy},
                          profile(rel, cur.mask, cur.ccw));
                end else begin
                    check("move_done_pulse",
                          {o_move_done, o_grip, o_rot_en, o_rot_ccw, o_state}, {1'b1, 12'h000});
                    mon_active = 1'b0;
                end
                rel++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge I_sys_clk_tb);
            #2;
        end
    endtask

    // Called 2 time units after a rising edge; the byte is taken on the next edge.
    task automatic send(input logic [7:0] b, input bit is_err, input bit runs, input int gap);
        I_rx_byte_tb  = b;
        I_rx_valid_tb = 1'b1;
        if (is_err) err_q.push_back(cyc + 1);
        if (runs)   move_q.push_back('{mask: b[3:0], ccw: b[4], gap: gap});
        tick(1);
        I_rx_valid_tb = 1'b0;
        I_rx_byte_tb  = 8'h00;
    endtask

    task automatic wait_idle(input int limit, input string name);
        int i;
        i = 0;
        while ((move_q.size() != 0 || mon_active) && i < limit) begin
            tick(1);
            i++;
        end
        check(name, (move_q.size() == 0 && !mon_active), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k;
        tick(2);
        check("rst_grip",     o_grip, 0);
        check("rst_rot_en",   o_rot_en, 0);
        check("rst_rot_ccw",  o_rot_ccw, 0);
        check("rst_busy",     o_busy, 0);
        check("rst_done",     o_move_done, 0);
        check("rst_cmd_err",  o_cmd_error, 0);
        check("rst_overflow", o_overflow, 0);
        check("rst_count",    o_fifo_count, 0);
        check("rst_state",    o_state, 0);
        I_rst_tb  = 1'b0;
        mon_flush = 1'b0;
        tick(1);

        // 1: single move, byte 0x01
        send(8'h01, 1'b0, 1'b1, 0);
        check("t1_count_after_push", o_fifo_count, 1);
        wait_idle(60, "t1_move_complete");
        tick(2);
        check("t1_busy_idle", o_busy, 0);
        check("t1_count_idle", o_fifo_count, 0);

        // 2: 0x1C then 0x03 two cycles apart, back-to-back moves
        send(8'h1C, 1'b0, 1'b1, 0);
        tick(1);
        send(8'h03, 1'b0, 1'b1, MOVE_LEN + 1);
        wait_idle(100, "t2_moves_complete");
        tick(2);
        check("t2_busy_idle", o_busy, 0);

        // 3: illegal bytes are dropped with an error pulse each
        send(8'h05, 1'b1, 1'b0, 0);
        check("t3_count_a", o_fifo_count, 0);
        send(8'h20, 1'b1, 1'b0, 0);
        check("t3_count_b", o_fifo_count, 0);
        send(8'h00, 1'b1, 1'b0, 0);
        check("t3_count_c", o_fifo_count, 0);
        tick(3);
        check("t3_errors_seen", err_q.size(), 0);
        check("t3_grip_quiet", o_grip, 0);
        check("t3_busy_quiet", o_busy, 0);

        // 4: overflow, push+pop on full FIFO, pointer wrap
        send(8'h01, 1'b0, 1'b1, 0);
        k = cyc;
        send(8'h02, 1'b0, 1'b1, MOVE_LEN + 1);
        send(8'h14, 1'b0, 1'b1, MOVE_LEN + 1);
        send(8'h08, 1'b0, 1'b1, MOVE_LEN + 1);
        send(8'h13, 1'b0, 1'b1, MOVE_LEN + 1);
        check("t4_count_full", o_fifo_count, DEPTH);
        check("t4_no_overflow_yet", o_overflow, 0);
        send(8'h04, 1'b0, 1'b0, 0);
        check("t4_overflow_set", o_overflow, 1);
        check("t4_count_after_drop", o_fifo_count, DEPTH);
        while (cyc < k + MOVE_LEN + 1) tick(1);
        send(8'h1C, 1'b0, 1'b1, MOVE_LEN + 1);
        check("t4_full_push_pop_count", o_fifo_count, DEPTH);
        wait_idle(250, "t4_moves_complete");
        tick(2);
        check("t4_count_drained", o_fifo_count, 0);
        check("t4_overflow_sticky", o_overflow, 1);

        // 5: reset in the middle of ROTATE
        send(8'h08, 1'b0, 1'b1, 0);
        k = cyc;
        send(8'h01, 1'b0, 1'b1, 0);
        while (cyc < k + 8) tick(1);
        check("t5_in_rotate_state", o_state, 2);
        check("t5_in_rotate_rot", o_rot_en, 4'h8);
        I_rst_tb  = 1'b1;
        mon_flush = 1'b1;
        tick(1);
        I_rst_tb  = 1'b0;
        move_q.delete();
        err_q.delete();
        check("t5_rst_grip",     o_grip, 0);
        check("t5_rst_rot_en",   o_rot_en, 0);
        check("t5_rst_count",    o_fifo_count, 0);
        check("t5_rst_overflow", o_overflow, 0);
        check("t5_rst_state",    o_state, 0);
        tick(1);
        mon_flush = 1'b0;
        tick(1);
        send(8'h02, 1'b0, 1'b1, 0);
        wait_idle(60, "t5_move_after_reset");
        tick(3);
        check("t5_busy_idle", o_busy, 0);
        check("queues_empty", move_q.size() + err_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
